// File: rtl/rr_req_collector.sv
// Client-side front end for the round-robin arbiter: latches request pulses into a pending
// vector, retires granted requests with a done pulse and tracks wait/fairness statistics.
module rr_req_collector #(
  parameter int REQCNT     = 4,
  parameter int CNT_W      = 16,
  parameter int STARVE_LIM = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REQCNT-1:0]         pulse_i,
  output logic [REQCNT-1:0]         req_o,
  output logic                      req_val_o,
  input  logic [$clog2(REQCNT)-1:0] req_num_i,
  output logic [REQCNT-1:0]         done_o,
  output logic [REQCNT-1:0]         ovf_o,
  output logic [REQCNT-1:0]         starve_o,
  output logic [CNT_W-1:0]          max_wait_o,
  input  logic                      clr_stats_i
);

  localparam int IDX_W = $clog2(REQCNT);

  logic [REQCNT-1:0] r_req;
  logic              r_req_val;
  logic [REQCNT-1:0] r_done;
  logic [REQCNT-1:0] r_ovf;
  logic [REQCNT-1:0] r_starve;
  logic [CNT_W-1:0]  r_max_wait;
  logic [CNT_W-1:0]  r_wait_cnt [REQCNT];

  logic              w_num_ok;
  logic [REQCNT-1:0] w_grant;
  logic [REQCNT-1:0] w_req_nxt;
  logic [REQCNT-1:0] w_ovf_set;
  logic [REQCNT-1:0] w_starve_set;
  logic [CNT_W-1:0]  w_max;

  // Grants naming an idle client or an index beyond REQCNT are ignored.
  always_comb begin
    w_num_ok     = (32'(req_num_i) < 32'(REQCNT));
    w_grant      = '0;
    w_starve_set = '0;
    w_max        = r_max_wait;
    for (int i = 0; i < REQCNT; i++) begin
      w_grant[i]      = r_req_val & w_num_ok & r_req[i] & (req_num_i == IDX_W'(i));
      w_starve_set[i] = (r_wait_cnt[i] >= CNT_W'(STARVE_LIM));
      if (r_wait_cnt[i] > w_max) begin
        w_max = r_wait_cnt[i];
      end
    end
    // A pulse coinciding with its own grant re-arms the client instead of overflowing.
    w_req_nxt = pulse_i | (r_req & ~w_grant);
    w_ovf_set = pulse_i & r_req & ~w_grant;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req      <= '0;
      r_req_val  <= 1'b0;
      r_done     <= '0;
      r_ovf      <= '0;
      r_starve   <= '0;
      r_max_wait <= '0;
      for (int i = 0; i < REQCNT; i++) begin
        r_wait_cnt[i] <= '0;
      end
    end else begin
      r_req     <= w_req_nxt;
      r_req_val <= |w_req_nxt;
      r_done    <= w_grant;
      for (int i = 0; i < REQCNT; i++) begin
        if (!r_req[i] || w_grant[i]) begin
          r_wait_cnt[i] <= '0;
        end else if (r_wait_cnt[i] != '1) begin
          r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
        end
      end
      if (clr_stats_i) begin
        r_ovf      <= '0;
        r_starve   <= '0;
        r_max_wait <= '0;
      end else begin
        r_ovf      <= r_ovf | w_ovf_set;
        r_starve   <= r_starve | w_starve_set;
        r_max_wait <= w_max;
      end
    end
  end

  assign req_o      = r_req;
  assign req_val_o  = r_req_val;
  assign done_o     = r_done;
  assign ovf_o      = r_ovf;
  assign starve_o   = r_starve;
  assign max_wait_o = r_max_wait;

endmodule

// File: tb/tb_rr_req_collector.sv
// Bench for rr_req_collector: per-scenario tasks with inline checks plus a done_o scoreboard
// fed from a small pending-request model each time stimulus is applied.
module tb_rr_req_collector;

  localparam int REQCNT = 4;
  localparam int CNT_W  = 4;
  localparam int LIM    = 8;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [REQCNT-1:0] pulse_i = '0;
  logic [REQCNT-1:0] req_o;
  logic              req_val_o;
  logic [1:0]        req_num_i = '0;
  logic [REQCNT-1:0] done_o;
  logic [REQCNT-1:0] ovf_o;
  logic [REQCNT-1:0] starve_o;
  logic [CNT_W-1:0]  max_wait_o;
  logic              clr_stats_i = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  logic [REQCNT-1:0] m_req = '0;
  logic [REQCNT-1:0] exp_done_q[$];

  rr_req_collector #(.REQCNT(REQCNT), .CNT_W(CNT_W), .STARVE_LIM(LIM)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pulse_i(pulse_i), .req_o(req_o), .req_val_o(req_val_o),
    .req_num_i(req_num_i), .done_o(done_o), .ovf_o(ovf_o), .starve_o(starve_o),
    .max_wait_o(max_wait_o), .clr_stats_i(clr_stats_i)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: one expected done vector per clock edge, compared half a cycle later.
  always @(negedge clk_i) begin
    if (exp_done_q.size() > 0) begin
      logic [REQCNT-1:0] exp_d;
      exp_d = exp_done_q.pop_front();
      n_total++;
      if (done_o !== exp_d) $display("FAIL done_scoreboard: got %b expected %b", done_o, exp_d);
      else n_pass++;
    end
  end

  // Apply current inputs for one clock edge; the model predicts done_o and pending bits.
  task automatic step();
    logic [REQCNT-1:0] g;
    g = '0;
    if (rst_i) begin
      m_req = '0;
    end else begin
      if ((|m_req) && m_req[req_num_i]) g[req_num_i] = 1'b1;
      m_req = pulse_i | (m_req & ~g);
    end
    exp_done_q.push_back(g);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    n_total++;
    if ({req_o, req_val_o, ovf_o, starve_o, max_wait_o} !== '0)
      $display("FAIL reset_state: got req=%b val=%b ovf=%b starve=%b max=%0d required all 0",
               req_o, req_val_o, ovf_o, starve_o, max_wait_o);
    else n_pass++;
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_single();
    pulse_i = 4'b0100; req_num_i = 2'd0;
    step();
    pulse_i = '0;
    n_total++;
    if (req_o !== 4'b0100 || req_val_o !== 1'b1)
      $display("FAIL single_req: got req=%b val=%b required 0100/1", req_o, req_val_o);
    else n_pass++;
    req_num_i = 2'd2;
    step();
    n_total++;
    if (done_o !== 4'b0100 || req_o !== 4'b0000 || req_val_o !== 1'b0 || max_wait_o !== 4'd0)
      $display("FAIL single_done: got done=%b req=%b val=%b max=%0d required 0100/0000/0/0",
               done_o, req_o, req_val_o, max_wait_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [REQCNT-1:0] exp_d;
    pulse_i = 4'b1111; req_num_i = 2'd0;
    step();
    pulse_i = '0;
    for (int k = 0; k < REQCNT; k++) begin
      req_num_i = 2'(k);
      step();
      exp_d = '0;
      exp_d[k] = 1'b1;
      n_total++;
      if (done_o !== exp_d) $display("FAIL rr_done_%0d: got %b required %b", k, done_o, exp_d);
      else n_pass++;
    end
    n_total++;
    if (max_wait_o !== 4'd3 || ovf_o !== 4'b0000 || req_o !== 4'b0000)
      $display("FAIL rr_stats: got max=%0d ovf=%b req=%b required 3/0000/0000",
               max_wait_o, ovf_o, req_o);
    else n_pass++;
  endtask

  task automatic test_repulse();
    pulse_i = 4'b0010; req_num_i = 2'd0;
    step();
    step();
    pulse_i = '0;
    n_total++;
    if (ovf_o !== 4'b0010 || req_o !== 4'b0010)
      $display("FAIL repulse_pending: got ovf=%b req=%b required 0010/0010", ovf_o, req_o);
    else n_pass++;
    pulse_i = 4'b0010; req_num_i = 2'd1;
    step();
    pulse_i = '0;
    n_total++;
    if (done_o !== 4'b0010 || req_o !== 4'b0010 || ovf_o !== 4'b0010)
      $display("FAIL repulse_on_grant: got done=%b req=%b ovf=%b required 0010/0010/0010",
               done_o, req_o, ovf_o);
    else n_pass++;
    step();
    n_total++;
    if (req_o !== 4'b0000 || req_val_o !== 1'b0)
      $display("FAIL repulse_retire: got req=%b val=%b required 0000/0", req_o, req_val_o);
    else n_pass++;
    clr_stats_i = 1'b1;
    step();
    clr_stats_i = 1'b0;
    n_total++;
    if (ovf_o !== 4'b0000 || max_wait_o !== 4'd0)
      $display("FAIL repulse_clear: got ovf=%b max=%0d required 0000/0", ovf_o, max_wait_o);
    else n_pass++;
  endtask

  task automatic test_starve();
    pulse_i = 4'b1001; req_num_i = 2'd1;
    step();
    pulse_i = 4'b0001; req_num_i = 2'd0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_total++;
      if (starve_o[3] !== (k >= LIM + 1))
        $display("FAIL starve_k%0d: got starve3=%b required %b", k, starve_o[3], (k >= LIM + 1));
      else n_pass++;
    end
    pulse_i = '0;
    n_total++;
    if (ovf_o !== 4'b0000 || req_o !== 4'b1001)
      $display("FAIL starve_state: got ovf=%b req=%b required 0000/1001", ovf_o, req_o);
    else n_pass++;
    clr_stats_i = 1'b1;
    step();
    clr_stats_i = 1'b0;
    n_total++;
    if (starve_o !== 4'b0000 || ovf_o !== 4'b0000 || max_wait_o !== 4'd0)
      $display("FAIL starve_clear: got starve=%b ovf=%b max=%0d required 0000/0000/0",
               starve_o, ovf_o, max_wait_o);
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic [CNT_W-1:0] exp_max;
    req_num_i = 2'd3;
    step();
    clr_stats_i = 1'b1; pulse_i = 4'b0001; req_num_i = 2'd2;
    step();
    clr_stats_i = 1'b0; pulse_i = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_max = (k - 1 > 15) ? 4'd15 : CNT_W'(k - 1);
      n_total++;
      if (max_wait_o !== exp_max)
        $display("FAIL saturate_k%0d: got max=%0d required %0d", k, max_wait_o, exp_max);
      else n_pass++;
    end
    req_num_i = 2'd0;
    step();
    n_total++;
    if (done_o !== 4'b0001 || max_wait_o !== 4'd15)
      $display("FAIL saturate_release: got done=%b max=%0d required 0001/15", done_o, max_wait_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clr_stats_i = 1'b1; pulse_i = 4'b1011; req_num_i = 2'd2;
    step();
    clr_stats_i = 1'b0; pulse_i = '0;
    step();
    step();
    n_total++;
    if (req_o !== 4'b1011 || max_wait_o === 4'd0)
      $display("FAIL midrst_setup: got req=%b max=%0d required 1011/nonzero", req_o, max_wait_o);
    else n_pass++;
    rst_i = 1'b1; pulse_i = 4'b0100; req_num_i = 2'd0;
    step();
    rst_i = 1'b0; pulse_i = '0; req_num_i = 2'd2;
    n_total++;
    if ({req_o, req_val_o, done_o, ovf_o, starve_o, max_wait_o} !== '0)
      $display("FAIL midrst_outputs: got req=%b val=%b done=%b ovf=%b starve=%b max=%0d required all 0",
               req_o, req_val_o, done_o, ovf_o, starve_o, max_wait_o);
    else n_pass++;
    pulse_i = 4'b0100; req_num_i = 2'd0;
    step();
    pulse_i = '0;
    n_total++;
    if (req_o !== 4'b0100 || req_val_o !== 1'b1)
      $display("FAIL midrst_accept: got req=%b val=%b required 0100/1", req_o, req_val_o);
    else n_pass++;
    req_num_i = 2'd2;
    step();
    n_total++;
    if (done_o !== 4'b0100 || req_o !== 4'b0000)
      $display("FAIL midrst_done: got done=%b req=%b required 0100/0000", done_o, req_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_repulse();
    test_starve();
    test_saturate();
    test_reset_mid();
    @(negedge clk_i);
    #1;
    n_total++;
    if (exp_done_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_done_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
